// File: rtl/display_scan_controller.sv
// display_scan_controller
// Scans an 8-digit common-anode 7-segment display. Each digit slot is
// BLANK_CYCLES dark cycles followed by CLK_DIV lit cycles. Frames are
// double-buffered: a shadow frame loaded over valid/ready is copied to the
// active frame only at the frame boundary, so the display never shows a torn
// frame.
// Optional: define DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
// state | meaning
// ------+--------------------------------------------------
// BLANK | anti-ghosting gap at slot start, segments dark
// LIT   | current digit index k driven with its pattern
module display_scan_controller #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    output logic [2:0]  index,
    output logic [7:0]  segments,
    output logic        frame_tick
);

    typedef enum logic {BLANK = 1'b0, LIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIT_LAST   = CNT_W'(CLK_DIV - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       k, k_nx;

    logic [31:0] active_data, shadow_data;
    logic [7:0]  active_dp, shadow_dp;
    logic        pending;

    logic        frame_end;
    logic        commit;
    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic        digit_blank;
    logic [7:0]  seg_nx;

    // State register: scan position within the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            k     <= k_nx;
        end
    end

    // Next-state logic: blank gap, then lit period, then advance digit
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        k_nx     = k;
        if (!enable) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            k_nx     = '0;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = LIT;
                        cnt_nx   = '0;
                    end
                end
                LIT: begin
                    if (cnt == LIT_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        k_nx     = k + 3'd1;
                    end
                end
                default: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Output logic: segment pattern for the next registered output
    always_comb begin
        nibble = active_data[{k, 2'b00} +: 4];
        case (nibble)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        // Digit 0 always shows; a lit dp keeps its digit visible.
        digit_blank = (k != 3'd0) && !active_dp[k]
                      && ((active_data >> {k, 2'b00}) == 32'd0);
`else
        digit_blank = 1'b0;
`endif
        if (enable && state == LIT && !digit_blank)
            seg_nx = ~{active_dp[k], glyph};
        else
            seg_nx = 8'hFF;
        frame_end = enable && state == LIT && k == 3'd7 && cnt == LIT_LAST;
        // Disabled display has no frame boundary, so commit freely.
        commit    = frame_end || !enable;
    end

    // Registered outputs: index and segments move on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            segments <= 8'hFF;
            index    <= '0;
        end else begin
            segments <= seg_nx;
            index    <= enable ? k : 3'd0;
        end
    end

    // Frame buffers: shadow captured on handshake, copied at commit
    always_ff @(posedge clk) begin
        if (rst) begin
            active_data <= '0;
            active_dp   <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
        end else if (commit && pending) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
            pending     <= 1'b0;
        end else if (load_valid && !pending) begin
            shadow_data <= load_data;
            shadow_dp   <= load_dp;
            pending     <= 1'b1;
        end
    end

    assign load_ready = ~pending;
    assign frame_tick = frame_end & ~rst;

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller (CLK_DIV=4, BLANK_CYCLES=1).
// The reference model tracks position in the frame as a plain cycle count
// and derives digit, blank/lit phase and frame boundary arithmetically.
module tb_display_scan_controller;

    localparam int CD    = 4;
    localparam int BL    = 1;
    localparam int SLOT  = CD + BL;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst, enable, load_valid;
    logic        load_ready, frame_tick;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic [2:0]  index;
    logic [7:0]  segments;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0]  seg7 [16];
    logic [31:0] m_active, m_shadow;
    logic [7:0]  m_adp, m_sdp;
    logic        m_pend;
    int          m_t;
    logic [7:0]  exp_seg;
    logic [2:0]  exp_idx;

    display_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(BL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp),
        .index(index), .segments(segments), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] digit_pattern(input int d);
        logic [3:0] nib;
        logic       blank;
        nib   = m_active[4*d +: 4];
        blank = 1'b0;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        blank = (d != 0) && !m_adp[d] && ((m_active >> (4*d)) == 32'd0);
`endif
        if (blank) return 8'hFF;
        return ~{m_adp[d], seg7[nib]};
    endfunction

    task automatic model_reset();
        m_active = '0; m_shadow = '0; m_adp = '0; m_sdp = '0;
        m_pend = 1'b0; m_t = 0; exp_seg = 8'hFF; exp_idx = 3'd0;
    endtask

    task automatic model_edge();
        logic accept, do_commit;
        if (rst) begin
            model_reset();
            return;
        end
        accept    = load_valid && !m_pend;
        do_commit = m_pend && (!enable || m_t == FRAME - 1);
        if (enable) begin
            exp_idx = 3'(m_t / SLOT);
            exp_seg = ((m_t % SLOT) < BL) ? 8'hFF : digit_pattern(m_t / SLOT);
            m_t     = (m_t + 1) % FRAME;
        end else begin
            exp_idx = 3'd0;
            exp_seg = 8'hFF;
            m_t     = 0;
        end
        if (do_commit) begin
            m_active = m_shadow; m_adp = m_sdp; m_pend = 1'b0;
        end else if (accept) begin
            m_shadow = load_data; m_sdp = load_dp; m_pend = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("index", 32'(index), 32'(exp_idx));
        chk("segments", 32'(segments), 32'(exp_seg));
        chk("load_ready", 32'(load_ready), 32'(!m_pend));
        chk("frame_tick", 32'(frame_tick), 32'(!rst && enable && m_t == FRAME - 1));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold valid until the transfer happens; a stuck handshake is a failure.
    task automatic send(input logic [31:0] d, input logic [7:0] dp);
        bit done;
        done = 1'b0;
        load_valid = 1'b1; load_data = d; load_dp = dp;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            done = !m_pend;
            tick();
        end
        load_valid = 1'b0;
        load_data  = $urandom;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        seg7 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst = 1'b1; enable = 1'b0; load_valid = 1'b0;
        load_data = '0; load_dp = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_segments", 32'(segments), 32'hFF);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        tick();

        rst = 1'b0; enable = 1'b1;
        run(2 * FRAME + 3);

        send(32'h76543210, 8'h00);
        run(2 * FRAME);

        send(32'hFEDCBA98, 8'h01);
        run(2 * FRAME);

        // Valid held high with data changing every cycle for two frames
        load_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            load_data = $urandom;
            load_dp   = 8'($urandom);
            tick();
        end
        load_valid = 1'b0;
        run(FRAME);

        // Drop enable mid-slot, load while dark, then resume
        run(SLOT + 2);
        enable = 1'b0;
        run(2);
        send(32'h13579BDF, 8'h80);
        run(2);
        enable = 1'b1;
        run(FRAME + 2);

        send(32'h00000120, 8'h00);
        run(2 * FRAME);
        send(32'h00000000, 8'h08);
        run(2 * FRAME);
        send(32'h00F00000, 8'h00);
        run(2 * FRAME);

        // Randomized traffic with occasional disable and one mid-frame reset
        for (int i = 0; i < 600; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000FFFF) : $urandom;
            load_dp    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            rst = (i == 300 || i == 301);
            tick();
        end
        rst = 1'b0; enable = 1'b1; load_valid = 1'b0;
        run(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
